// File: rtl/shift_pkg.sv
// shift_pkg: shared state type and sizing constants for the serial lamp-pattern transmitter.
package shift_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} tx_state_t;
  localparam int SHIFT_WIDTH   = 8;
  localparam int SHIFT_GAP_MAX = 15;
endpackage

// File: rtl/shift_tx_cnt.sv
// shift_tx_cnt: loadable up-counter with clear and enable.
// tc_o flags that the count being written at this edge equals term_i.
module shift_tx_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr_i ? '0 : load_i ? load_val_i : en_i ? cnt_q + W'(1) : cnt_q;
    tc_o  = cnt_d == term_i;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/shift_tx.sv
// shift_tx: serialises a word LSB-first with one we pulse per bit, then holds we low
// for GAP cycles so the receiver latches; done marks the last gap cycle.
module shift_tx
  import shift_pkg::*;
#(
  parameter int WIDTH = SHIFT_WIDTH,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             we,
  output logic             done
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(SHIFT_GAP_MAX + 1);
  tx_state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic ready_q, ready_d, sout_q, sout_d, we_q, we_d, done_q, done_d;
  logic accept, enter_latch, bit_tc, gap_tc;
  // bit 0 goes straight to sout on accept, so shreg holds only the bits still to send
  always_comb begin
    accept      = state_q == IDLE && valid && ready_q;
    enter_latch = state_q == SHIFT && bit_tc;
    state_d     = accept ? SHIFT : enter_latch ? LATCH : (state_q == LATCH && done_q) ? IDLE : state_q;
    shreg_d     = accept ? data >> 1 : state_q == SHIFT ? shreg_q >> 1 : shreg_q;
    sout_d      = accept ? data[0] : state_d == SHIFT ? shreg_q[0] : 1'b0;
    we_d        = state_d == SHIFT;
    ready_d     = state_d == IDLE;
    done_d      = state_d == LATCH && gap_tc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      ready_q <= 1'b0;
      sout_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ready_q <= ready_d;
      sout_q  <= sout_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  shift_tx_cnt #(.W(BW)) u_bit_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (accept),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == SHIFT),
    .term_i     (BW'(WIDTH)),
    .tc_o       (bit_tc)
  );
  // the gap count reaches GAP-1 in the last latch cycle, which is when done must show
  shift_tx_cnt #(.W(GW)) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (enter_latch),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (state_q == LATCH),
    .term_i     (GW'(GAP - 1)),
    .tc_o       (gap_tc)
  );
  assign ready = ready_q;
  assign sout  = sout_q;
  assign we    = we_q;
  assign done  = done_q;
endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: drives shift_tx into a receiver model and scoreboards the latched words.
module tb_shift_tx;
  import shift_pkg::*;
  localparam int W = SHIFT_WIDTH;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [W-1:0] data = '0, data3 = '0;
  logic valid = 1'b0, valid3 = 1'b0;
  logic ready, sout, we, done, ready3, sout3, we3, done3;
  logic [W-1:0] rx_sh, rx_par, sb_exp;
  logic rx_we_q, rx_upd;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] bb[3];
  int acc[3];
  int tests = 0, fails = 0, cyc = 0, ovl = 0, dones = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_tx #(.WIDTH(W), .GAP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data(data), .valid(valid),
    .ready(ready), .sout(sout), .we(we), .done(done)
  );
  shift_tx #(.WIDTH(W), .GAP(3)) u_g3 (
    .clk(clk), .rst_n(rst_n), .data(data3), .valid(valid3),
    .ready(ready3), .sout(sout3), .we(we3), .done(done3)
  );

  // receiver: shifts right inserting at MSB, parallel output on first edge with we low
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_sh <= '0; rx_par <= '0; rx_we_q <= 1'b0; rx_upd <= 1'b0;
    end else begin
      if (we) rx_sh <= {sout, rx_sh[W-1:1]};
      if (!we && rx_we_q) rx_par <= rx_sh;
      rx_upd  <= !we && rx_we_q;
      rx_we_q <= we;
    end

  always @(negedge clk) begin
    if (ready && we) ovl++;
    if (done) dones++;
    if (rx_upd) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $error("FAIL sb_unexpected: observed %0h expected no word", rx_par);
      end else begin
        sb_exp = exp_q.pop_front();
        assert (rx_par === sb_exp) else begin
          fails++;
          $error("FAIL sb_word: observed %0h expected %0h", rx_par, sb_exp);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 50) begin @(negedge clk); n++; end
    check("ready_wait", ready, 1);
  endtask

  // one word with full bit/timing checks; data is scrambled every cycle after accept
  task automatic send(input logic [W-1:0] w, input string tag);
    wait_ready();
    data = w; valid = 1'b1; exp_q.push_back(w);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      data = ~data ^ W'(k);
      check({tag, "_we"}, we, 1);
      check({tag, "_sout"}, sout, w[k]);
      check({tag, "_nordy"}, ready, 0);
      @(negedge clk);
    end
    check({tag, "_we_fall"}, we, 0);
    check({tag, "_done"}, done, 1);
    @(negedge clk);
    check({tag, "_done_end"}, done, 0);
    check({tag, "_ready"}, ready, 1);
    check({tag, "_rx"}, rx_par, w);
  endtask

  initial begin
    logic [W-1:0] w3;
    int n, t, a0, a1, d0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_we", we, 0);
    check("rst_sout", sout, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    #1 check("rel_ready_low", ready, 0);
    @(negedge clk);
    check("rel_ready", ready, 1);

    send(8'hA5, "a5");

    bb = '{8'h01, 8'h80, 8'hFF};
    n = 0; t = 0;
    valid = 1'b1; data = bb[0];
    while (n < 3 && t < 60) begin
      if (ready) begin
        acc[n] = cyc; exp_q.push_back(bb[n]); n++;
        @(negedge clk); t++;
        if (n < 3) data = bb[n];
      end else begin
        @(negedge clk); t++;
      end
    end
    valid = 1'b0;
    check("bb_count", n, 3);
    check("bb_period1", acc[1] - acc[0], 10);
    check("bb_period2", acc[2] - acc[1], 10);
    repeat (12) @(negedge clk);
    check("bb_drained", exp_q.size(), 0);

    wait_ready();
    d0 = dones;
    data = 8'hC3; valid = 1'b1; exp_q.push_back(8'hC3);
    @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    data = 8'h3C; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (20) @(negedge clk);
    check("ign_rx", rx_par, 8'hC3);
    check("ign_dones", dones - d0, 1);
    check("ign_drained", exp_q.size(), 0);

    wait_ready();
    data = 8'hF0; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_sout_b4", sout, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_we", we, 0);
    check("mid_sout", sout, 0);
    check("mid_done", done, 0);
    check("mid_ready", ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_rel_low", ready, 0);
    @(negedge clk);
    check("mid_rel_ready", ready, 1);
    send(8'h5A, "5a");

    w3 = 8'h69; n = 0;
    valid3 = 1'b1; data3 = w3;
    while (!ready3 && n < 50) begin @(negedge clk); n++; end
    check("g3_ready_wait", ready3, 1);
    a0 = cyc; a1 = 0;
    @(negedge clk);
    for (int c = 0; c < 12; c++) begin
      if (c < W) begin
        check("g3_we", we3, 1);
        check("g3_sout", sout3, w3[c]);
      end else begin
        check("g3_gap_we", we3, 0);
        check("g3_done", done3, c == 10);
        check("g3_ready", ready3, c == 11);
      end
      if (c == 11) a1 = cyc;
      else @(negedge clk);
    end
    check("g3_period", a1 - a0, 12);
    @(negedge clk);
    valid3 = 1'b0;

    send(8'h0F, "0f");

    repeat (15) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    check("ready_we_overlap", ovl, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/shift_tx.md
# shift_tx

Parallel-to-serial transmitter that drives the 8-bit serial shift-register receiver in the traffic-light datapath. It accepts a word through a valid/ready handshake and serialises it LSB-first on `sout`, with `we` high for exactly one clock per bit. It then holds `we` low for a programmable gap so the receiver transfers its shift register to its parallel output. It sits between the controller that computes lamp patterns and the receiver chain feeding the lamp drivers.

## Interface
- `WIDTH`, default 8: bits per word; must equal the receiver width.
- `GAP`, default 1: cycles `we` is held low after the last bit (the latch window); legal range 1..15.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `data`  in  WIDTH: word to send; sampled only on the accept edge.
- `valid`  in  1: `data` is valid.
- `ready`  out  1: block can accept a word.
- `sout`  out  1: serial data to the receiver `in`.
- `we`  out  1: shift enable to the receiver `we`.
- `done`  out  1: one-cycle pulse when the receiver has latched the word.

## Operation
- States:
  - IDLE: `ready`=1, `we`=0, `sout`=0.
  - SHIFT: `we`=1, `sout` = current bit.
  - LATCH: `we`=0, `sout`=0, gap counter running.
- IDLE -> SHIFT on an accept (`valid`&&`ready` at a rising edge).
  - Copy `data` into the internal shift register.
  - Clear the bit counter.
- SHIFT:
  - Each cycle, present shreg[0] on `sout`, then shift the register right by 1 and increment the bit counter.
  - After WIDTH cycles, go to LATCH.
- LATCH: count GAP cycles.
  - Assert `done` in the last LATCH cycle.
  - Then return to IDLE.
- Bit order is LSB first. The receiver shifts right and inserts at the MSB, so after WIDTH shifts it holds `data` unchanged.
- `valid` outside IDLE is ignored: no queueing and no error.
- `data` changes after the accept edge have no effect on the word in flight.
- Bit counter width is clog2(WIDTH+1); gap counter width is 4 bits. Neither counter wraps: each is cleared on entry to its state.
- Reset (asserted at any time, including mid-word):
  - State goes to IDLE; shreg and counters go to 0.
  - `sout`=0, `we`=0, `done`=0, `ready`=0.
  - `ready` rises at the first rising edge after `rst_n` deasserts.
  - A partially shifted word is dropped and never retransmitted.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Accept at edge E0:
  - bit 0 is on `sout` with `we`=1 during cycle E0..E1;
  - bit k is on `sout` during cycle k;
  - `we` falls at edge E0+WIDTH;
  - `done` is high during cycle E0+WIDTH+GAP-1;
  - `ready` is high again from edge E0+WIDTH+GAP.
- Word period is WIDTH+GAP+1 cycles: 10 with the default parameters, for back-to-back words with `valid` held high.
- The receiver samples `sout` on the same edge that ends each `we`=1 cycle. Its parallel output updates on the first edge with `we`=0, i.e. E0+WIDTH+1.
- `ready` and `we` are never high in the same cycle.

## Structure
- Package `shift_pkg`:
  - state enum `tx_state_t` {IDLE, SHIFT, LATCH};
  - constant `SHIFT_WIDTH`=8, shared with the receiver instantiation;
  - constant `SHIFT_GAP_MAX`=15.
- One sub-module, `shift_tx_cnt`: a loadable up-counter with clear, enable and terminal-count output. It is instantiated twice, once as the bit counter and once as the gap counter.
- The FSM, shift register and output registers live in `shift_tx`.
- The testbench instantiates `shift_tx` driving a receiver model, whose parallel output is the check point.

## Test plan
- Reset release, then `data`=8'hA5 with `valid` held 1 cycle:
  - `sout` over the 8 `we` cycles = 1,0,1,0,0,1,0,1;
  - receiver parallel output = 8'hA5 at E0+9;
  - `done` pulses at E0+8.
- Back-to-back words 8'h01, 8'h80, 8'hFF with `valid` held high:
  - accepts exactly 10 cycles apart;
  - receiver outputs 01, 80, FF in order;
  - `ready`&&`we` never both high.
- `valid` pulsed with `data`=8'h3C during SHIFT of 8'hC3:
  - the 8'h3C request is ignored;
  - receiver shows 8'hC3;
  - no second `done`.
- `rst_n` asserted after 4 bits of 8'hF0:
  - `we`, `sout`, `done` go to 0 immediately (asynchronously);
  - after release, `ready`=1 in one cycle;
  - a new word 8'h5A is delivered intact.
- GAP=3, `data`=8'h69:
  - `we` is low for 3 cycles before `ready` returns;
  - `done` is in the 3rd gap cycle;
  - word period is 12 cycles.
- `data` toggled every cycle after accepting 8'h0F: the receiver still shows 8'h0F.
